// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, default operand width and scheduler states.
package alu_pkg;

  localparam int unsigned DATA_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ADD   = 2'd0,
    SUB   = 2'd1,
    INV_A = 2'd2,
    ROR_B = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant
);

  int idx;

  // Scan from the farthest offset down so the nearest hit to rr_ptr is written last and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    idx         = 0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= int'(NUM_REQ)) begin
        idx = idx - int'(NUM_REQ);
      end
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external registered ALU among NUM_REQ requesters, one operation at a time.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  opcode_e [NUM_REQ-1:0]          req_opcode,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_b,
  output opcode_e                        alu_opcode,
  output logic [DATA_W-1:0]              alu_a,
  output logic [DATA_W-1:0]              alu_b,
  input  logic [DATA_W:0]                alu_c,
  output logic                           rsp_valid,
  output logic [IDX_W-1:0]               rsp_id,
  output logic [DATA_W:0]                rsp_data,
  input  logic                           rsp_ready,
  output logic                           busy
);

  sched_state_e state_q, state_d;

  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   rr_ptr_d;
  opcode_e            op_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [IDX_W-1:0]   id_q;
  logic [DATA_W:0]    rsp_data_q;
  logic [IDX_W-1:0]   rsp_id_q;

  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req        (req_valid),
    .rr_ptr     (rr_ptr_q),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .grant      (grant)
  );

  // Pointer moves one past the winner so the winner goes to the back of the queue.
  assign rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; accept marks the edge on which a request is taken.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; req_ready is only offered while idle.
  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: req_ready = grant;
      EXEC: busy = 1'b1;
      CAPT: busy = 1'b1;
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
      end
      default: req_ready = '0;
    endcase
  end

  // Latch the winner's operation and advance the round-robin pointer on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      op_q     <= ADD;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
    end else if (accept) begin
      rr_ptr_q <= rr_ptr_d;
      op_q     <= req_opcode[grant_idx];
      a_q      <= req_a[grant_idx];
      b_q      <= req_b[grant_idx];
      id_q     <= grant_idx;
    end
  end

  // Capture the ALU result one cycle after EXEC and hold it through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else if (state_q == CAPT) begin
      rsp_data_q <= alu_c;
      rsp_id_q   <= id_q;
    end
  end

  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler with a registered ALU model attached.
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  localparam int N = 4;

  logic                 clk;
  logic                 reset;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  opcode_e [N-1:0]      req_opcode;
  logic [N-1:0][3:0]    req_a;
  logic [N-1:0][3:0]    req_b;
  opcode_e              alu_opcode;
  logic [3:0]           alu_a;
  logic [3:0]           alu_b;
  logic [4:0]           alu_c;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic [4:0]           rsp_data;
  logic                 rsp_ready;
  logic                 busy;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_rr_scheduler #(
    .NUM_REQ(N),
    .DATA_W (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opcode(req_opcode),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_opcode(alu_opcode),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External registered ALU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_c <= '0;
    end else begin
      case (alu_opcode)
        ADD:     alu_c <= {alu_a[3], alu_a} + {alu_b[3], alu_b};
        SUB:     alu_c <= {alu_a[3], alu_a} - {alu_b[3], alu_b};
        INV_A:   alu_c <= ~{alu_a[3], alu_a};
        default: alu_c <= {4'b0000, |alu_b};
      endcase
    end
  end

  // Reference arithmetic on plain integers.
  function automatic logic [4:0] ref_result(opcode_e op, logic [3:0] a, logic [3:0] b);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      ADD:     r = sa + sb;
      SUB:     r = sa - sb;
      INV_A:   r = -sa - 1;
      default: r = (b != 4'd0) ? 1 : 0;
    endcase
    return 5'(r);
  endfunction

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive request i from a posedge+1 point; returns at the EXEC sample point.
  task automatic issue(input int i, input opcode_e op, input logic [3:0] a, input logic [3:0] b,
                       output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    req_valid[i]  = 1'b1;
    req_opcode[i] = op;
    req_a[i]      = a;
    req_b[i]      = b;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {req_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, busy});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    int first = -1;
    int busy_cnt = 0;
    bit rdy_seen = 1'b0;
    apply_reset();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_opcode[0] = ADD; req_a[0] = 4'd3; req_b[0] = 4'd4;
    @(negedge clk); #1;
    n_cmp++;
    if ({req_ready, busy} !== {4'b0001, 1'b0}) begin
      n_fail++;
      $display("FAIL single_accept: got ready=%b busy=%b expected ready=0001 busy=0",
               req_ready, busy);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      busy_cnt += int'(busy);
      if (req_ready != '0) rdy_seen = 1'b1;
      if (rsp_valid && first < 0) begin
        first = k;
        n_cmp++;
        if ({rsp_id, rsp_data} !== {2'd0, 5'd7}) begin
          n_fail++;
          $display("FAIL single_rsp: got id=%0d data=%b expected id=0 data=00111", rsp_id,
                   rsp_data);
        end
      end
    end
    n_cmp++;
    if (first != 3) begin
      n_fail++;
      $display("FAIL single_latency: got %0d expected 3", first);
    end
    n_cmp++;
    if (busy_cnt != 3) begin
      n_fail++;
      $display("FAIL single_busy_cycles: got %0d expected 3", busy_cnt);
    end
    n_cmp++;
    if (rdy_seen) begin
      n_fail++;
      $display("FAIL single_ready_pulse: got extra req_ready expected none after accept");
    end
  endtask

  task automatic test_opcodes();
    opcode_e    ops [5] = '{SUB, INV_A, ROR_B, ROR_B, ADD};
    logic [3:0] as  [5] = '{4'b1000, 4'd5, 4'd3, 4'd0, 4'b1111};
    logic [3:0] bs  [5] = '{4'd7, 4'd2, 4'd0, 4'b1111, 4'b1000};
    logic [4:0] exp [5] = '{5'b10001, 5'b11010, 5'b00000, 5'b00001, 5'b10111};
    bit ok, ok2;
    apply_reset();
    rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      issue(t % N, ops[t], as[t], bs[t], ok);
      wait_rsp(ok2);
      n_cmp++;
      if (!ok || !ok2 || rsp_data !== exp[t] || rsp_id !== 2'(t % N)) begin
        n_fail++;
        $display("FAIL opcode_%0d: got ok=%0d/%0d id=%0d data=%b expected id=%0d data=%b", t,
                 ok, ok2, rsp_id, rsp_data, t % N, exp[t]);
      end
    end
  endtask

  task automatic test_fairness();
    int got;
    bit ok;
    apply_reset();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1; req_opcode[i] = ADD; req_a[i] = 4'(i); req_b[i] = 4'd1;
    end
    for (int gi = 0; gi < 5; gi++) begin
      got = -1;
      for (int n = 0; n < 10 && got < 0; n++) begin
        @(negedge clk); #1;
        for (int i = 0; i < N; i++) if (req_ready[i]) got = i;
      end
      n_cmp++;
      if (got != gi % N) begin
        n_fail++;
        $display("FAIL fair_grant_%0d: got %0d expected %0d", gi, got, gi % N);
      end
      @(negedge clk); #1;
      wait_rsp(ok);
      n_cmp++;
      if (!ok || int'(rsp_id) != got || rsp_data !== ref_result(ADD, 4'(got), 4'd1)) begin
        n_fail++;
        $display("FAIL fair_rsp_%0d: got ok=%0d id=%0d data=%b expected id=%0d", gi, ok,
                 rsp_id, rsp_data, got);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    bit ok, ok2;
    apply_reset();
    rsp_ready = 1'b0;
    issue(2, SUB, 4'd2, 4'd5, ok);
    req_valid[3] = 1'b1; req_opcode[3] = ADD; req_a[3] = 4'd1; req_b[3] = 4'd1;
    wait_rsp(ok2);
    n_cmp++;
    if (!ok || !ok2 || {rsp_id, rsp_data} !== {2'd2, 5'b11101}) begin
      n_fail++;
      $display("FAIL bp_rsp: got ok=%0d/%0d id=%0d data=%b expected id=2 data=11101", ok, ok2,
               rsp_id, rsp_data);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 2'd2, 5'b11101, 4'b0000}) begin
        n_fail++;
        $display("FAIL bp_stall_%0d: got v=%b id=%0d data=%b ready=%b expected 1/2/11101/0000",
                 k, rsp_valid, rsp_id, rsp_data, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({busy, rsp_valid, req_ready} !== {1'b0, 1'b0, 4'b1000}) begin
      n_fail++;
      $display("FAIL bp_release: got busy=%b v=%b ready=%b expected 0/0/1000", busy, rsp_valid,
               req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit rsp_seen = 1'b0;
    apply_reset();
    rsp_ready = 1'b1;
    issue(2, ADD, 4'd1, 4'd2, ok);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (!ok ||
        {req_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got ok=%0d %b expected all zero", ok,
               {req_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (rsp_valid) rsp_seen = 1'b1;
    end
    n_cmp++;
    if (rsp_seen) begin
      n_fail++;
      $display("FAIL midreset_no_rsp: got a response expected none");
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_ptr: got ready=%b expected 0001", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_withdraw();
    bit ok;
    bit g1 = 1'b0;
    bit id1 = 1'b0;
    bit rsp0 = 1'b0;
    apply_reset();
    rsp_ready = 1'b1;
    issue(0, ADD, 4'd1, 4'd1, ok);
    req_valid[1] = 1'b1; req_opcode[1] = SUB; req_a[1] = 4'd3; req_b[1] = 4'd1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (req_ready[1]) g1 = 1'b1;
      if (rsp_valid && rsp_id == 2'd1) id1 = 1'b1;
      if (rsp_valid && rsp_id == 2'd0 && rsp_data == 5'd2) rsp0 = 1'b1;
    end
    n_cmp++;
    if (g1 || id1) begin
      n_fail++;
      $display("FAIL withdraw_req1: got grant=%0d rsp=%0d expected 0/0", g1, id1);
    end
    n_cmp++;
    if (!ok || !rsp0) begin
      n_fail++;
      $display("FAIL withdraw_rsp0: got ok=%0d seen=%0d expected 1/1", ok, rsp0);
    end
  endtask

  // Random traffic checked cycle by cycle against a phase/queue model of the scheduler.
  task automatic test_random();
    int phase = 0;
    int ptr = 0;
    int clr = -1;
    int g;
    int lid = 0;
    opcode_e lop = ADD;
    logic [3:0] la = '0, lb = '0;
    logic [3:0] exp_ready;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      if (clr >= 0) begin
        req_valid[clr] = 1'b0;
        clr = -1;
      end
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i]  = 1'b1;
          req_opcode[i] = opcode_e'($urandom_range(0, 3));
          req_a[i]      = 4'($urandom);
          req_b[i]      = 4'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk); #1;
      g = -1;
      if (phase == 0) begin
        for (int k = N - 1; k >= 0; k--) if (req_valid[(ptr + k) % N]) g = (ptr + k) % N;
      end
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
      n_cmp++;
      if ({req_ready, busy, rsp_valid} !== {exp_ready, phase != 0, phase == 3}) begin
        n_fail++;
        $display("FAIL rand_ctrl_%0d: got ready=%b busy=%b v=%b expected %b/%0d/%0d", cyc,
                 req_ready, busy, rsp_valid, exp_ready, phase != 0, phase == 3);
      end
      if (phase != 0) begin
        n_cmp++;
        if ({alu_opcode, alu_a, alu_b} !== {lop, la, lb}) begin
          n_fail++;
          $display("FAIL rand_alu_%0d: got %b expected %b", cyc, {alu_opcode, alu_a, alu_b},
                   {lop, la, lb});
        end
      end
      if (phase == 3) begin
        n_cmp++;
        if ({rsp_id, rsp_data} !== {2'(lid), ref_result(lop, la, lb)}) begin
          n_fail++;
          $display("FAIL rand_rsp_%0d: got id=%0d data=%b expected id=%0d data=%b", cyc,
                   rsp_id, rsp_data, lid, ref_result(lop, la, lb));
        end
      end
      case (phase)
        0: if (g >= 0) begin
             lid = g; lop = req_opcode[g]; la = req_a[g]; lb = req_b[g];
             ptr = (g + 1) % N; clr = g; phase = 1;
           end
        1: phase = 2;
        2: phase = 3;
        default: if (rsp_ready) phase = 0;
      endcase
    end
    req_valid = '0;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_opcode = '{default: ADD};
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    test_reset();
    test_single();
    test_opcodes();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
